// File: rtl/rf_access_ctrl_if.sv
// ---------------------------------------------------------------------------
// rf_access_ctrl_if
//   Bundles every non-clock signal of rf_access_ctrl: the issue handshake from
//   decode, the register-file read/write ports, the operand handshake towards
//   execute, the writeback request, the PC redirect and the scoreboard debug
//   outputs.
//
//   modport master : the access controller (drives selects, operands, PC)
//   modport slave  : the surrounding core / register file / execute stage
//
//   Parameters
//     NREG : number of architectural registers (x0 hardwired to zero)
//     XLEN : data width
// ---------------------------------------------------------------------------
interface rf_access_ctrl_if #(
    parameter int NREG = 32,
    parameter int XLEN = 32
);
    // issue side
    logic            iss_vld;
    logic            iss_rdy;
    logic [4:0]      iss_rs1;
    logic [4:0]      iss_rs2;
    logic [4:0]      iss_rd;
    logic            iss_rd_we;
    // register file read port
    logic [NREG-1:0] reg_sel_rs1;
    logic [NREG-1:0] reg_sel_rs2;
    logic [XLEN-1:0] reg_rs1;
    logic [XLEN-1:0] reg_rs2;
    // operand stage towards execute
    logic            opd_vld;
    logic            opd_rdy;
    logic [XLEN-1:0] opd_rs1_val;
    logic [XLEN-1:0] opd_rs2_val;
    logic [4:0]      opd_rd;
    logic            opd_rd_we;
    // writeback
    logic            wb_vld;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic [NREG-1:0] reg_sel_rd;
    logic [XLEN-1:0] reg_rd;
    // PC redirect
    logic            pc_upd_vld;
    logic [XLEN-1:0] pc_upd;
    logic            pc_in_vld;
    logic [XLEN-1:0] pc_in;
    // scoreboard observation
    logic [NREG-1:0] sb_busy;
    logic            sb_err;

    modport master (
        input  iss_vld, iss_rs1, iss_rs2, iss_rd, iss_rd_we,
        output iss_rdy,
        output reg_sel_rs1, reg_sel_rs2,
        input  reg_rs1, reg_rs2,
        output opd_vld, opd_rs1_val, opd_rs2_val, opd_rd, opd_rd_we,
        input  opd_rdy,
        input  wb_vld, wb_rd, wb_data,
        output reg_sel_rd, reg_rd,
        input  pc_upd_vld, pc_upd,
        output pc_in_vld, pc_in,
        output sb_busy, sb_err
    );

    modport slave (
        output iss_vld, iss_rs1, iss_rs2, iss_rd, iss_rd_we,
        input  iss_rdy,
        input  reg_sel_rs1, reg_sel_rs2,
        output reg_rs1, reg_rs2,
        input  opd_vld, opd_rs1_val, opd_rs2_val, opd_rd, opd_rd_we,
        output opd_rdy,
        output wb_vld, wb_rd, wb_data,
        input  reg_sel_rd, reg_rd,
        output pc_upd_vld, pc_upd,
        input  pc_in_vld, pc_in,
        input  sb_busy, sb_err
    );
endinterface

// File: rtl/rf_access_ctrl.sv
// ---------------------------------------------------------------------------
// rf_access_ctrl
//   Core-side register-file access controller. Decodes source/destination
//   indices into one-hot selects, tracks in-flight destinations in a
//   per-register scoreboard, stalls issue on RAW/WAW hazards (bypassing a
//   writeback that lands in the same cycle), registers the operand pair
//   behind a valid/ready handshake and turns PC redirects into a registered
//   one-cycle write strobe.
//
//   Ports
//     clk : clock
//     rst : synchronous reset, active-high
//     bus : rf_access_ctrl_if.master (issue, reg-file read/write, operand
//           handshake, writeback, PC redirect, scoreboard debug)
// ---------------------------------------------------------------------------
module rf_access_ctrl #(
    parameter int NREG = 32,
    parameter int XLEN = 32
) (
    input  logic             clk,
    input  logic             rst,
    rf_access_ctrl_if.master bus
);

    // One-hot decode; x0 never produces a select.
    function automatic logic [NREG-1:0] onehot(input logic [4:0] idx);
        logic [NREG-1:0] r;
        r = '0;
        if (idx != 5'd0) begin
            r[idx] = 1'b1;
        end
        return r;
    endfunction

    // Source operand with same-cycle writeback bypass; x0 reads as zero.
    function automatic logic [XLEN-1:0] src_val(
        input logic [4:0]      idx,
        input logic [XLEN-1:0] rf_val,
        input logic            wb_v,
        input logic [4:0]      wb_idx,
        input logic [XLEN-1:0] wb_val
    );
        if (idx == 5'd0) begin
            return '0;
        end else if (wb_v && (wb_idx == idx)) begin
            return wb_val;
        end else begin
            return rf_val;
        end
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic            opd_vld_q,  opd_vld_d;
    logic [XLEN-1:0] opd_rs1_q,  opd_rs1_d;
    logic [XLEN-1:0] opd_rs2_q,  opd_rs2_d;
    logic [4:0]      opd_rd_q,   opd_rd_d;
    logic            opd_we_q,   opd_we_d;
    logic [NREG-1:0] sb_q,       sb_d;
    logic            sb_err_q,   sb_err_d;
    logic            pc_vld_q,   pc_vld_d;
    logic [XLEN-1:0] pc_q,       pc_d;

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    logic wb_act;
    logic wb_hit_rs1, wb_hit_rs2, wb_hit_rd;
    logic haz_rs1, haz_rs2, haz_waw;
    logic opd_free;
    logic issue;

    // A writeback to the register being checked retires the pending write
    // in this very cycle, so it lifts the hazard instead of causing one.
    assign wb_act     = bus.wb_vld && (bus.wb_rd != 5'd0);
    assign wb_hit_rs1 = bus.wb_vld && (bus.wb_rd == bus.iss_rs1);
    assign wb_hit_rs2 = bus.wb_vld && (bus.wb_rd == bus.iss_rs2);
    assign wb_hit_rd  = bus.wb_vld && (bus.wb_rd == bus.iss_rd);

    assign haz_rs1 = (bus.iss_rs1 != 5'd0) && sb_q[bus.iss_rs1] && !wb_hit_rs1;
    assign haz_rs2 = (bus.iss_rs2 != 5'd0) && sb_q[bus.iss_rs2] && !wb_hit_rs2;
    assign haz_waw = bus.iss_rd_we && (bus.iss_rd != 5'd0)
                   && sb_q[bus.iss_rd] && !wb_hit_rd;

    // The operand register can take a new entry when empty or draining now.
    assign opd_free = !opd_vld_q || bus.opd_rdy;

    // Ready deliberately ignores iss_vld so decode may depend on it.
    assign bus.iss_rdy = !haz_rs1 && !haz_rs2 && !haz_waw && opd_free;
    assign issue       = bus.iss_vld && bus.iss_rdy;

    // ------------------------------------------------------------------
    // Register-file ports (combinational)
    // ------------------------------------------------------------------
    assign bus.reg_sel_rs1 = onehot(bus.iss_rs1);
    assign bus.reg_sel_rs2 = onehot(bus.iss_rs2);
    assign bus.reg_sel_rd  = bus.wb_vld ? onehot(bus.wb_rd) : '0;
    assign bus.reg_rd      = bus.wb_data;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        opd_vld_d = opd_vld_q;
        opd_rs1_d = opd_rs1_q;
        opd_rs2_d = opd_rs2_q;
        opd_rd_d  = opd_rd_q;
        opd_we_d  = opd_we_q;
        sb_d      = sb_q;
        sb_err_d  = sb_err_q;
        pc_vld_d  = bus.pc_upd_vld;
        pc_d      = pc_q;

        // Operand stage: load on issue, otherwise drain on ready.
        if (issue) begin
            opd_vld_d = 1'b1;
            opd_rs1_d = src_val(bus.iss_rs1, bus.reg_rs1,
                                bus.wb_vld, bus.wb_rd, bus.wb_data);
            opd_rs2_d = src_val(bus.iss_rs2, bus.reg_rs2,
                                bus.wb_vld, bus.wb_rd, bus.wb_data);
            opd_rd_d  = bus.iss_rd;
            opd_we_d  = bus.iss_rd_we;
        end else if (bus.opd_rdy) begin
            opd_vld_d = 1'b0;
        end

        // Scoreboard: retire first so a same-index issue (set) wins.
        if (wb_act) begin
            if (!sb_q[bus.wb_rd]) begin
                sb_err_d = 1'b1;
            end
            sb_d[bus.wb_rd] = 1'b0;
        end
        if (issue && bus.iss_rd_we && (bus.iss_rd != 5'd0)) begin
            sb_d[bus.iss_rd] = 1'b1;
        end
        sb_d[0] = 1'b0;

        // PC data holds between redirects; only the strobe is a pulse.
        if (bus.pc_upd_vld) begin
            pc_d = bus.pc_upd;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            opd_vld_q <= 1'b0;
            opd_rs1_q <= '0;
            opd_rs2_q <= '0;
            opd_rd_q  <= '0;
            opd_we_q  <= 1'b0;
            sb_q      <= '0;
            sb_err_q  <= 1'b0;
            pc_vld_q  <= 1'b0;
            pc_q      <= '0;
        end else begin
            opd_vld_q <= opd_vld_d;
            opd_rs1_q <= opd_rs1_d;
            opd_rs2_q <= opd_rs2_d;
            opd_rd_q  <= opd_rd_d;
            opd_we_q  <= opd_we_d;
            sb_q      <= sb_d;
            sb_err_q  <= sb_err_d;
            pc_vld_q  <= pc_vld_d;
            pc_q      <= pc_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.opd_vld     = opd_vld_q;
    assign bus.opd_rs1_val = opd_rs1_q;
    assign bus.opd_rs2_val = opd_rs2_q;
    assign bus.opd_rd      = opd_rd_q;
    assign bus.opd_rd_we   = opd_we_q;
    assign bus.sb_busy     = sb_q;
    assign bus.sb_err      = sb_err_q;
    assign bus.pc_in_vld   = pc_vld_q;
    assign bus.pc_in       = pc_q;

endmodule
